wbs2axim_bridge: RTL and testbench

WBS2AXIM_BRIDGE -- requirements
Module: wbs2axim_bridge

---
 rtl/wbs2axim_bridge.sv | 180 ++++++++++++++++++
 tb/tb_wbs2axim_bridge.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbs2axim_bridge.sv
// Purpose: bridge a pipelined Wishbone slave port onto a single-beat AXI4 master, one transaction at a time.
// Latency: request accepted at cycle 0, AXI valid at cycle 1, response at cycle 2, ack/err at cycle 3 (ready slave).
// Backpressure: o_wb_stall is high whenever a transaction is in flight; AXI valids hold until their handshake.
module wbs2axim_bridge #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 28,
  localparam int AXI_LSBS      = $clog2(AXI_DATA_WIDTH) - 3,
  localparam int WB_ADDR_BITS  = AXI_ADDR_WIDTH - AXI_LSBS
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  // Wishbone pipelined slave
  input  logic                          i_wb_cyc,
  input  logic                          i_wb_stb,
  input  logic                          i_wb_we,
  input  logic [WB_ADDR_BITS-1:0]       i_wb_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     i_wb_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   i_wb_sel,
  output logic                          o_wb_stall,
  output logic                          o_wb_ack,
  output logic                          o_wb_err,
  output logic [AXI_DATA_WIDTH-1:0]     o_wb_data,
  // AXI write address
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  // AXI write data
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  // AXI write response
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [1:0]                    m_axi_bresp,
  // AXI read address
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_arid,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  // AXI read data
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA} state_t;

  state_t                        state, state_nxt;
  logic                          accept;
  logic                          abandon;
  logic [AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [AXI_DATA_WIDTH-1:0]     wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_q;
  logic [AXI_DATA_WIDTH-1:0]     rdata_q;
  logic                          awvalid_q;
  logic                          wvalid_q;
  logic                          drop_q;
  logic                          ack_q;
  logic                          err_q;
  logic                          unused_inputs;

  // Only single-beat bursts are issued, so rlast and the low response bit carry no information.
  assign unused_inputs = &{1'b0, m_axi_rlast, m_axi_bresp[0], m_axi_rresp[0]};

  assign accept  = (state == IDLE) && i_wb_cyc && i_wb_stb;
  // Once the master has walked away from the cycle, its response must never be signalled.
  assign abandon = drop_q || !i_wb_cyc;

  // Fixed single-beat, full-width, INCR burst attributes.
  assign m_axi_awid    = '0;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(AXI_LSBS);
  assign m_axi_awburst = 2'b01;
  assign m_axi_arid    = '0;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'(AXI_LSBS);
  assign m_axi_arburst = 2'b01;
  assign m_axi_wlast   = 1'b1;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_arvalid = (state == READ);
  assign m_axi_bready  = (state == WRESP);
  assign m_axi_rready  = (state == RDATA);

  assign o_wb_stall = (state != IDLE);
  assign o_wb_ack   = ack_q;
  assign o_wb_err   = err_q;
  assign o_wb_data  = rdata_q;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a write leaves WRITE only once both AW and W have handshaken, in any order.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = i_wb_we ? WRITE : READ;
      WRITE: if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) state_nxt = WRESP;
      WRESP: if (m_axi_bvalid) state_nxt = IDLE;
      READ:  if (m_axi_arready) state_nxt = RDATA;
      RDATA: if (m_axi_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, per-channel valid tracking, response pulses and read-data holding register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      drop_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (state != IDLE && !i_wb_cyc) begin
        drop_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= {i_wb_addr, {AXI_LSBS{1'b0}}};
            wdata_q   <= i_wb_data;
            wstrb_q   <= i_wb_sel;
            drop_q    <= 1'b0;
            awvalid_q <= i_wb_we;
            wvalid_q  <= i_wb_we;
          end
        end
        WRITE: begin
          if (m_axi_awready) awvalid_q <= 1'b0;
          if (m_axi_wready)  wvalid_q  <= 1'b0;
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            ack_q <= !abandon && !m_axi_bresp[1];
            err_q <= !abandon &&  m_axi_bresp[1];
          end
        end
        RDATA: begin
          if (m_axi_rvalid) begin
            rdata_q <= m_axi_rdata;
            ack_q   <= !abandon && !m_axi_rresp[1];
            err_q   <= !abandon &&  m_axi_rresp[1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wbs2axim_bridge.sv
// Purpose: directed and randomized checks of wbs2axim_bridge against a cycle-count/transaction model.
// Latency: expects response at 3 + channel delays cycles after accept.
// Backpressure: AXI slave model inserts configurable ready/valid delays per channel.
module tb_wbs2axim_bridge;
  localparam int DW   = 128;
  localparam int SW   = DW / 8;
  localparam int AW   = 28;
  localparam int LSBS = 4;
  localparam int WBA  = AW - LSBS;

  logic           clk = 1'b0;
  logic           i_reset = 1'b1;
  logic           i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [WBA-1:0] i_wb_addr = '0;
  logic [DW-1:0]  i_wb_data = '0;
  logic [SW-1:0]  i_wb_sel = '0;
  logic           o_wb_stall, o_wb_ack, o_wb_err;
  logic [DW-1:0]  o_wb_data;
  logic           m_axi_awvalid, m_axi_awready = 1'b0;
  logic [AW-1:0]  m_axi_awaddr;
  logic [3:0]     m_axi_awid;
  logic [7:0]     m_axi_awlen;
  logic [2:0]     m_axi_awsize;
  logic [1:0]     m_axi_awburst;
  logic           m_axi_wvalid, m_axi_wready = 1'b0;
  logic [DW-1:0]  m_axi_wdata;
  logic [SW-1:0]  m_axi_wstrb;
  logic           m_axi_wlast;
  logic           m_axi_bvalid = 1'b0, m_axi_bready;
  logic [1:0]     m_axi_bresp = 2'b00;
  logic           m_axi_arvalid, m_axi_arready = 1'b0;
  logic [AW-1:0]  m_axi_araddr;
  logic [3:0]     m_axi_arid;
  logic [7:0]     m_axi_arlen;
  logic [2:0]     m_axi_arsize;
  logic [1:0]     m_axi_arburst;
  logic           m_axi_rvalid = 1'b0, m_axi_rready;
  logic [DW-1:0]  m_axi_rdata = '0;
  logic [1:0]     m_axi_rresp = 2'b00;
  logic           m_axi_rlast = 1'b0;

  wbs2axim_bridge dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr),
    .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err), .o_wb_data(o_wb_data),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
  );

  always #5 clk = ~clk;

  // Slave configuration, written only by the stimulus block.
  int            cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
  logic [1:0]    cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [DW-1:0] cfg_rdata = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [SW-1:0] exp_wstrb = '0;

  // Slave state and monitors, written only by the slave process.
  int            aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit            aw_done = 0, w_done = 0, b_pend = 0, r_pend = 0;
  int            aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int            addr_bad = 0, data_bad = 0, const_bad = 0;
  logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
  logic [SW-1:0] last_wstrb = '0;

  // AXI slave model: drives inputs and counts handshakes at the falling edge, i.e. the
  // handshake that the next rising edge will complete.
  always @(negedge clk) begin
    if (i_reset) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_rvalid = 0;
      aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
      aw_cnt = cfg_aw_d; w_cnt = cfg_w_d; ar_cnt = cfg_ar_d;
    end else begin
      if (b_pend) begin
        if (b_cnt > 0) begin m_axi_bvalid = 0; b_cnt--; end
        else m_axi_bvalid = 1;
      end else m_axi_bvalid = 0;
      if (m_axi_bvalid && m_axi_bready) begin b_hs++; b_pend = 0; end

      if (r_pend) begin
        if (r_cnt > 0) begin m_axi_rvalid = 0; r_cnt--; end
        else m_axi_rvalid = 1;
      end else m_axi_rvalid = 0;
      if (m_axi_rvalid && m_axi_rready) begin r_hs++; r_pend = 0; end

      if (m_axi_awvalid) begin
        if (aw_cnt > 0) begin m_axi_awready = 0; aw_cnt--; end
        else m_axi_awready = 1;
        if (m_axi_awaddr !== exp_addr) addr_bad++;
        if (m_axi_awid !== 4'd0 || m_axi_awlen !== 8'd0 || m_axi_awsize !== 3'(LSBS) || m_axi_awburst !== 2'b01)
          const_bad++;
        if (m_axi_awready) begin aw_hs++; aw_done = 1; last_awaddr = m_axi_awaddr; end
      end else begin
        m_axi_awready = 0; aw_cnt = cfg_aw_d;
      end

      if (m_axi_wvalid) begin
        if (w_cnt > 0) begin m_axi_wready = 0; w_cnt--; end
        else m_axi_wready = 1;
        if (m_axi_wdata !== exp_wdata || m_axi_wstrb !== exp_wstrb) data_bad++;
        if (m_axi_wlast !== 1'b1) const_bad++;
        if (m_axi_wready) begin w_hs++; w_done = 1; last_wstrb = m_axi_wstrb; end
      end else begin
        m_axi_wready = 0; w_cnt = cfg_w_d;
      end

      if (aw_done && w_done) begin
        aw_done = 0; w_done = 0; b_pend = 1; b_cnt = cfg_b_d; m_axi_bresp = cfg_bresp;
      end

      if (m_axi_arvalid) begin
        if (ar_cnt > 0) begin m_axi_arready = 0; ar_cnt--; end
        else m_axi_arready = 1;
        if (m_axi_araddr !== exp_addr) addr_bad++;
        if (m_axi_arid !== 4'd0 || m_axi_arlen !== 8'd0 || m_axi_arsize !== 3'(LSBS) || m_axi_arburst !== 2'b01)
          const_bad++;
        if (m_axi_arready) begin
          ar_hs++; last_araddr = m_axi_araddr;
          r_pend = 1; r_cnt = cfg_r_d; m_axi_rdata = cfg_rdata; m_axi_rresp = cfg_rresp; m_axi_rlast = 1;
        end
      end else begin
        m_axi_arready = 0; ar_cnt = cfg_ar_d;
      end
    end
  end

  // Bench bookkeeping.
  int            n_tests = 0, n_fail = 0;
  int            r_ack_cnt, r_err_cnt, r_both, r_ack_cyc, r_idle_cyc;
  logic [7:0]    r_post_rst;
  logic [DW-1:0] r_data_at_ack;
  int            aw0, w0, b0, ar0, r0, abad0, dbad0, cbad0;
  logic [DW-1:0] model_rdata = '0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one Wishbone request and observe it until the bridge is idle again.
  // drop_at / rst_at: cycle (after accept) at which cyc is dropped / reset is pulsed; -1 = never.
  task automatic run_txn(input bit we, input logic [WBA-1:0] addr, input logic [DW-1:0] data,
                         input logic [SW-1:0] sel, input int drop_at, input int rst_at);
    int n;
    r_ack_cnt = 0; r_err_cnt = 0; r_both = 0; r_ack_cyc = -1; r_idle_cyc = -1;
    r_post_rst = 8'hFF; r_data_at_ack = '0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
    abad0 = addr_bad; dbad0 = data_bad; cbad0 = const_bad;
    exp_addr  = AW'(addr) * AW'(SW);
    exp_wdata = data;
    exp_wstrb = sel;
    @(negedge clk);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = we; i_wb_addr = addr; i_wb_data = data; i_wb_sel = sel;
    n = 0;
    while (n < 80) begin
      @(negedge clk);
      n++;
      if (n == 1) i_wb_stb = 0;
      if (o_wb_ack) r_ack_cnt++;
      if (o_wb_err) r_err_cnt++;
      if (o_wb_ack && o_wb_err) r_both++;
      if ((o_wb_ack || o_wb_err) && r_ack_cyc < 0) begin r_ack_cyc = n; r_data_at_ack = o_wb_data; end
      if (!o_wb_stall && r_idle_cyc < 0) r_idle_cyc = n;
      if (n == drop_at) i_wb_cyc = 0;
      if (n == rst_at) begin i_reset = 1; i_wb_cyc = 0; i_wb_stb = 0; end
      if (rst_at >= 0 && n == rst_at + 1)
        r_post_rst = {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                      m_axi_rready, o_wb_stall, o_wb_ack, o_wb_err};
      if (rst_at >= 0 && n == rst_at + 2) i_reset = 0;
      if (o_wb_ack || o_wb_err) i_wb_cyc = 0;
      if (r_idle_cyc >= 0 && n >= r_idle_cyc + 2 && (rst_at < 0 || n > rst_at + 2)) break;
    end
    i_wb_cyc = 0; i_wb_stb = 0;
  endtask

  // Reference model: one AXI transaction per request, response 3 cycles after accept plus
  // whatever the slave adds; ack/err from resp[1] unless the master abandoned the cycle.
  task automatic expect_txn(input string tag, input bit we, input bit drop);
    int         done;
    logic [1:0] resp;
    bit         exp_ack, exp_err;
    resp = we ? cfg_bresp : cfg_rresp;
    done = we ? 3 + ((cfg_aw_d > cfg_w_d) ? cfg_aw_d : cfg_w_d) + cfg_b_d : 3 + cfg_ar_d + cfg_r_d;
    exp_ack = !drop && !resp[1];
    exp_err = !drop && resp[1];
    check({tag, ".idle_cyc"}, DW'(r_idle_cyc), DW'(done));
    check({tag, ".resp_cyc"}, DW'(r_ack_cyc), drop ? DW'(-1) : DW'(done));
    check({tag, ".ack_cnt"}, DW'(r_ack_cnt), DW'(exp_ack));
    check({tag, ".err_cnt"}, DW'(r_err_cnt), DW'(exp_err));
    check({tag, ".ack_and_err"}, DW'(r_both), DW'(0));
    check({tag, ".aw_hs"}, DW'(aw_hs - aw0), DW'(we));
    check({tag, ".w_hs"}, DW'(w_hs - w0), DW'(we));
    check({tag, ".b_hs"}, DW'(b_hs - b0), DW'(we));
    check({tag, ".ar_hs"}, DW'(ar_hs - ar0), DW'(!we));
    check({tag, ".r_hs"}, DW'(r_hs - r0), DW'(!we));
    check({tag, ".addr_stable"}, DW'(addr_bad - abad0), DW'(0));
    check({tag, ".wdata_stable"}, DW'(data_bad - dbad0), DW'(0));
    check({tag, ".axi_consts"}, DW'(const_bad - cbad0), DW'(0));
    if (!we) begin
      model_rdata = cfg_rdata;
      if (!drop) check({tag, ".data_at_resp"}, r_data_at_ack, cfg_rdata);
    end
    check({tag, ".wb_data_hold"}, o_wb_data, model_rdata);
  endtask

  task automatic set_delays(input int aw_d, input int w_d, input int b_d, input int ar_d, input int r_d);
    cfg_aw_d = aw_d; cfg_w_d = w_d; cfg_b_d = b_d; cfg_ar_d = ar_d; cfg_r_d = r_d;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.stall", DW'(o_wb_stall), DW'(0));
    check("rst.ack_err", DW'({o_wb_ack, o_wb_err}), DW'(0));
    check("rst.valids", DW'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), DW'(0));
    check("rst.readys", DW'({m_axi_bready, m_axi_rready}), DW'(0));
    check("rst.wb_data", o_wb_data, DW'(0));
    i_reset = 0;
    @(negedge clk);

    // Minimum-latency write to word 0x10.
    set_delays(0, 0, 0, 0, 0); cfg_bresp = 2'b00;
    run_txn(1'b1, 24'h10, {16{8'hA5}}, 16'hFFFF, -1, -1);
    expect_txn("wr_basic", 1'b1, 1'b0);
    check("wr_basic.awaddr", DW'(last_awaddr), DW'(28'h100));
    check("wr_basic.wstrb", DW'(last_wstrb), DW'(16'hFFFF));

    // Read from word 3 with a slow AR channel.
    set_delays(0, 0, 0, 4, 0); cfg_rresp = 2'b00; cfg_rdata = DW'(32'h1234);
    run_txn(1'b0, 24'h3, '0, 16'hFFFF, -1, -1);
    expect_txn("rd_slow_ar", 1'b0, 1'b0);
    check("rd_slow_ar.araddr", DW'(last_araddr), DW'(28'h30));

    // AW late / W early, then the reverse.
    set_delays(3, 0, 0, 0, 0);
    run_txn(1'b1, 24'h55, {4{32'hDEADBEEF}}, 16'h0F0F, -1, -1);
    expect_txn("wr_aw_late", 1'b1, 1'b0);
    set_delays(0, 3, 0, 0, 0);
    run_txn(1'b1, 24'h56, {4{32'hCAFEF00D}}, 16'hF0F0, -1, -1);
    expect_txn("wr_w_late", 1'b1, 1'b0);

    // Read with SLVERR.
    set_delays(0, 0, 0, 0, 0); cfg_rresp = 2'b10; cfg_rdata = DW'(64'h0BAD_0BAD_0BAD_0BAD);
    run_txn(1'b0, 24'h7, '0, 16'hFFFF, -1, -1);
    expect_txn("rd_slverr", 1'b0, 1'b0);

    // Master drops cyc while the write response is outstanding.
    set_delays(0, 0, 3, 0, 0); cfg_bresp = 2'b00;
    run_txn(1'b1, 24'h20, {4{32'h11112222}}, 16'hFFFF, 3, -1);
    expect_txn("wr_cyc_drop", 1'b1, 1'b1);

    // Reset while AW is still waiting for ready.
    set_delays(5, 0, 0, 0, 0);
    run_txn(1'b1, 24'h40, {4{32'h33334444}}, 16'hFFFF, -1, 2);
    check("wr_reset.post_rst", DW'(r_post_rst), DW'(0));
    check("wr_reset.resp", DW'(r_ack_cnt + r_err_cnt), DW'(0));
    check("wr_reset.aw_hs", DW'(aw_hs - aw0), DW'(0));
    model_rdata = '0;
    check("wr_reset.wb_data", o_wb_data, model_rdata);
    set_delays(0, 0, 0, 0, 0);
    run_txn(1'b1, 24'h41, {4{32'h55556666}}, 16'h00FF, -1, -1);
    expect_txn("wr_after_rst", 1'b1, 1'b0);

    // Randomized mix of reads and writes with random delays and responses.
    for (int i = 0; i < 16; i++) begin
      bit            we;
      logic [WBA-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      we = 1'($urandom_range(0, 1));
      a  = WBA'($urandom);
      d  = {$urandom, $urandom, $urandom, $urandom};
      s  = SW'($urandom);
      set_delays(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      cfg_bresp = 2'($urandom_range(0, 3));
      cfg_rresp = 2'($urandom_range(0, 3));
      cfg_rdata = {$urandom, $urandom, $urandom, $urandom};
      run_txn(we, a, d, s, -1, -1);
      expect_txn("rand", we, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
